// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcode and state encodings, iteration count and operand helper
// shared by the ex_muldiv multiply/divide unit.
package muldiv_pkg;
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;
    localparam int         MD_ITER  = 32;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SIGN = 2'd2} md_state_e;

    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply step or one restoring shift-subtract
// divide step on the {hi,lo} accumulator pair.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n
);
    logic [32:0] sum, rem_sh, diff;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : 33'd0);
        rem_sh = {hi, lo[31]};
        // remainder stays below the divisor, so bit 32 of diff is a clean borrow flag
        diff   = rem_sh - {1'b0, b};
        hi_n   = is_div ? (diff[32] ? rem_sh[31:0] : diff[31:0]) : sum[32:1];
        lo_n   = is_div ? {lo[30:0], ~diff[32]} : {sum[0], lo[31:1]};
    end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO, 33-cycle
// iterative path; define MULDIV_FAST_MULT_EN for single-cycle multiplies.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        EX_start,
    input  logic [1:0]  EX_MDOp,
    input  logic [31:0] EX_D1,
    input  logic [31:0] EX_D2,
    input  logic        EX_HI_WEN,
    input  logic        EX_LO_WEN,
    input  logic        EX_abort,
    output logic        MD_busy,
    output logic        MD_done,
    output logic [31:0] MD_HI,
    output logic [31:0] MD_LO
);
    md_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
    logic        is_signed, op_div, fast, start;
    logic [31:0] a_mag, b_mag, step_hi, step_lo;
    logic [63:0] prod;

    assign is_signed = !(EX_MDOp == MD_MULTU || EX_MDOp == MD_DIVU);
    assign op_div    = !(EX_MDOp == MD_MULT || EX_MDOp == MD_MULTU);
    assign start     = EX_start && !EX_abort && state_q == IDLE;
    assign a_mag     = md_mag(EX_D1, is_signed);
    assign b_mag     = md_mag(EX_D2, is_signed);
    assign prod      = {acc_hi_q, acc_lo_q};
`ifdef MULDIV_FAST_MULT_EN
    assign fast = !op_div;
`else
    assign fast = 1'b0;
`endif

    muldiv_step u_step (
        .is_div(is_div_q), .hi(acc_hi_q), .lo(acc_lo_q), .b(b_q),
        .hi_n(step_hi), .lo_n(step_lo)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (EX_abort)
            state_d = IDLE;
        else
            case (state_q)
                IDLE:    state_d = EX_start ? (fast ? SIGN : RUN) : IDLE;
                RUN:     state_d = (cnt_q == 5'd0) ? SIGN : RUN;
                default: state_d = IDLE;
            endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            hi_d = EX_HI_WEN ? EX_D1 : hi_q;
            lo_d = EX_LO_WEN ? EX_D1 : lo_q;
            if (start) begin
                acc_hi_d = '0;
                acc_lo_d = a_mag;
                b_d      = b_mag;
                is_div_d = op_div;
                neg_d    = is_signed && (EX_D1[31] ^ EX_D2[31]);
                rneg_d   = is_signed && EX_D1[31];
                cnt_d    = 5'(MD_ITER - 1);
`ifdef MULDIV_FAST_MULT_EN
                if (fast) {acc_hi_d, acc_lo_d} = {32'd0, a_mag} * {32'd0, b_mag};
`endif
            end
        end else if (state_q == RUN) begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q - 5'd1;
        end else if (!EX_abort) begin
            // quotient takes the xor of operand signs, remainder the dividend's sign
            done_d       = 1'b1;
            {hi_d, lo_d} = is_div_q ? {rneg_q ? -acc_hi_q : acc_hi_q, neg_q ? -acc_lo_q : acc_lo_q}
                                    : (neg_q ? -prod : prod);
        end
    end

    always_comb begin
        MD_busy = state_q != IDLE;
        MD_done = done_q;
        MD_HI   = hi_q;
        MD_LO   = lo_q;
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv (latency, results,
// abort, reset, HI/LO strobes, and the fast-multiply build when enabled).
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic        clock = 1'b0, reset = 1'b0, EX_start = 1'b0, EX_HI_WEN = 1'b0, EX_LO_WEN = 1'b0, EX_abort = 1'b0;
    logic [1:0]  EX_MDOp = 2'b00;
    logic [31:0] EX_D1 = '0, EX_D2 = '0;
    logic        MD_busy, MD_done;
    logic [31:0] MD_HI, MD_LO;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    int          checks = 0, fails = 0, bc, dc;
    logic [31:0] hi_pre, lo_pre, hi_r, lo_r;
    logic        busy_r;

    ex_muldiv dut (
        .clock(clock), .reset(reset), .EX_start(EX_start), .EX_MDOp(EX_MDOp),
        .EX_D1(EX_D1), .EX_D2(EX_D2), .EX_HI_WEN(EX_HI_WEN), .EX_LO_WEN(EX_LO_WEN),
        .EX_abort(EX_abort), .MD_busy(MD_busy), .MD_done(MD_done), .MD_HI(MD_HI), .MD_LO(MD_LO)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2);
        @(negedge clock);
        EX_MDOp = op; EX_D1 = d1; EX_D2 = d2; EX_start = 1'b1;
        @(posedge clock);
        #1 EX_start = 1'b0;
    endtask

    // i = k means the negedge following edge N+k, where N samples the start
    task automatic run_op(input logic [1:0] op, input logic [31:0] d1, input logic [31:0] d2, input int lat);
        issue(op, d1, d2);
        bc = 0; dc = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            if (MD_busy) bc++;
            if (MD_done) dc++;
            if (i == lat - 1) begin hi_pre = MD_HI; lo_pre = MD_LO; end
            if (i == lat) begin hi_r = MD_HI; lo_r = MD_LO; end
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if (MD_HI !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h expected %h", MD_HI, 32'h0); end
        checks++; if (MD_LO !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h expected %h", MD_LO, 32'h0); end
        checks++; if (MD_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", MD_busy); end
        checks++; if (MD_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", MD_done); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        run_op(MD_MULT, 32'hFFFFFFFD, 32'd7, MUL_LAT);
        checks++; if (lo_pre !== 32'h0) begin fails++; $display("FAIL mult_lo_early: got %h expected %h", lo_pre, 32'h0); end
        checks++; if (hi_r !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi: got %h expected %h", hi_r, 32'hFFFFFFFF); end
        checks++; if (lo_r !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo: got %h expected %h", lo_r, 32'hFFFFFFEB); end
        checks++; if (bc !== MUL_LAT) begin fails++; $display("FAIL mult_busy_cycles: got %0d expected %0d", bc, MUL_LAT); end
        checks++; if (dc !== 1) begin fails++; $display("FAIL mult_done_pulses: got %0d expected 1", dc); end
        run_op(MD_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, MUL_LAT);
        checks++; if ({hi_r, lo_r} !== 64'h3FFFFFFF00000001) begin fails++; $display("FAIL mult_max: got %h expected %h", {hi_r, lo_r}, 64'h3FFFFFFF00000001); end
        run_op(MD_MULT, 32'd5, 32'hFFFFFFFC, MUL_LAT);
        checks++; if ({hi_r, lo_r} !== 64'hFFFFFFFFFFFFFFEC) begin fails++; $display("FAIL mult_neg_d2: got %h expected %h", {hi_r, lo_r}, 64'hFFFFFFFFFFFFFFEC); end
        run_op(MD_MULTU, 32'h80000000, 32'd2, MUL_LAT);
        checks++; if ({hi_r, lo_r} !== 64'h0000000100000000) begin fails++; $display("FAIL multu_carry: got %h expected %h", {hi_r, lo_r}, 64'h0000000100000000); end
    endtask

    task automatic test_div;
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, DIV_LAT);
        checks++; if (lo_r !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_lo: got %h expected %h", lo_r, 32'hFFFFFFFD); end
        checks++; if (hi_r !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_hi: got %h expected %h", hi_r, 32'hFFFFFFFF); end
        checks++; if (bc !== DIV_LAT || dc !== 1) begin fails++; $display("FAIL div_timing: got busy %0d done %0d expected busy 33 done 1", bc, dc); end
        run_op(MD_DIVU, 32'd7, 32'd0, DIV_LAT);
        checks++; if ({hi_r, lo_r} !== {32'd7, 32'hFFFFFFFF}) begin fails++; $display("FAIL divu_zero: got %h expected %h", {hi_r, lo_r}, {32'd7, 32'hFFFFFFFF}); end
        run_op(MD_DIV, 32'hFFFFFFFB, 32'd0, DIV_LAT);
        checks++; if ({hi_r, lo_r} !== {32'hFFFFFFFB, 32'd1}) begin fails++; $display("FAIL div_zero_neg: got %h expected %h", {hi_r, lo_r}, {32'hFFFFFFFB, 32'd1}); end
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT);
        checks++; if ({hi_r, lo_r} !== {32'd0, 32'h80000000}) begin fails++; $display("FAIL div_overflow: got %h expected %h", {hi_r, lo_r}, {32'd0, 32'h80000000}); end
        run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, DIV_LAT);
        checks++; if ({hi_r, lo_r} !== {32'd1, 32'hFFFFFFFD}) begin fails++; $display("FAIL div_neg_divisor: got %h expected %h", {hi_r, lo_r}, {32'd1, 32'hFFFFFFFD}); end
        run_op(MD_DIVU, 32'hFFFFFFFF, 32'd10, DIV_LAT);
        checks++; if ({hi_r, lo_r} !== {32'd5, 32'h19999999}) begin fails++; $display("FAIL divu_big: got %h expected %h", {hi_r, lo_r}, {32'd5, 32'h19999999}); end
    endtask

    task automatic test_ignore_start;
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        dc = 0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        EX_start = 1'b1; EX_MDOp = MD_MULT; EX_D1 = 32'd2; EX_D2 = 32'd3;
        @(posedge clock);
        #1 EX_start = 1'b0;
        for (int i = 5; i <= 40; i++) begin
            @(negedge clock);
            if (MD_done) dc++;
            if (i == 33) begin hi_r = MD_HI; lo_r = MD_LO; end
            if (i == 34) busy_r = MD_busy;
        end
        checks++; if ({hi_r, lo_r} !== 64'hFFFFFFFE00000001) begin fails++; $display("FAIL multu_max: got %h expected %h", {hi_r, lo_r}, 64'hFFFFFFFE00000001); end
        checks++; if (dc !== 1) begin fails++; $display("FAIL busy_start_done: got %0d expected 1", dc); end
        checks++; if (busy_r !== 1'b0) begin fails++; $display("FAIL busy_start_restart: got %b expected 0", busy_r); end
    endtask

    task automatic test_abort;
        issue(MD_DIVU, 32'd100, 32'd3);
        repeat (9) @(posedge clock);
        @(negedge clock);
        checks++; if (MD_busy !== 1'b1) begin fails++; $display("FAIL abort_pre_busy: got %b expected 1", MD_busy); end
        EX_abort = 1'b1;
        @(posedge clock);
        #1 EX_abort = 1'b0;
        @(negedge clock);
        checks++; if (MD_busy !== 1'b0) begin fails++; $display("FAIL abort_idle: got %b expected 0", MD_busy); end
        dc = 0;
        repeat (40) begin @(negedge clock); if (MD_done) dc++; end
        checks++; if (dc !== 0) begin fails++; $display("FAIL abort_done: got %0d expected 0", dc); end
        checks++; if ({MD_HI, MD_LO} !== {hi_r, lo_r}) begin fails++; $display("FAIL abort_hilo: got %h expected %h", {MD_HI, MD_LO}, {hi_r, lo_r}); end
        @(negedge clock);
        EX_start = 1'b1; EX_abort = 1'b1; EX_MDOp = MD_DIV;
        @(posedge clock);
        #1 begin EX_start = 1'b0; EX_abort = 1'b0; end
        @(negedge clock);
        checks++; if (MD_busy !== 1'b0) begin fails++; $display("FAIL abort_over_start: got %b expected 0", MD_busy); end
    endtask

    task automatic test_reset_mid;
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (19) @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if ({MD_HI, MD_LO} !== 64'h0) begin fails++; $display("FAIL reset_mid_hilo: got %h expected %h", {MD_HI, MD_LO}, 64'h0); end
        checks++; if (MD_busy !== 1'b0 || MD_done !== 1'b0) begin fails++; $display("FAIL reset_mid_flags: got busy %b done %b expected 0 0", MD_busy, MD_done); end
        @(negedge clock);
        reset = 1'b1;
        dc = 0;
        repeat (40) begin @(negedge clock); if (MD_done) dc++; end
        checks++; if (dc !== 0 || MD_busy !== 1'b0) begin fails++; $display("FAIL reset_mid_after: got done %0d busy %b expected 0 0", dc, MD_busy); end
    endtask

    task automatic test_strobe;
        @(negedge clock);
        EX_HI_WEN = 1'b1; EX_D1 = 32'h12345678;
        @(posedge clock);
        #1 EX_HI_WEN = 1'b0;
        @(negedge clock);
        checks++; if (MD_HI !== 32'h12345678) begin fails++; $display("FAIL mthi: got %h expected %h", MD_HI, 32'h12345678); end
        checks++; if (MD_LO !== 32'h0) begin fails++; $display("FAIL mthi_lo_kept: got %h expected %h", MD_LO, 32'h0); end
        EX_LO_WEN = 1'b1; EX_D1 = 32'hCAFEF00D;
        @(posedge clock);
        #1 EX_LO_WEN = 1'b0;
        @(negedge clock);
        checks++; if (MD_LO !== 32'hCAFEF00D) begin fails++; $display("FAIL mtlo: got %h expected %h", MD_LO, 32'hCAFEF00D); end
        issue(MD_DIVU, 32'd100, 32'd7);
        repeat (2) @(posedge clock);
        @(negedge clock);
        EX_HI_WEN = 1'b1; EX_D1 = 32'hDEADBEEF;
        @(posedge clock);
        #1 EX_HI_WEN = 1'b0;
        @(negedge clock);
        checks++; if (MD_HI !== 32'h12345678) begin fails++; $display("FAIL mthi_busy: got %h expected %h", MD_HI, 32'h12345678); end
        repeat (40) @(negedge clock);
        checks++; if ({MD_HI, MD_LO} !== {32'd2, 32'd14}) begin fails++; $display("FAIL divu_after_strobe: got %h expected %h", {MD_HI, MD_LO}, {32'd2, 32'd14}); end
        EX_LO_WEN = 1'b1; EX_start = 1'b1; EX_MDOp = MD_DIVU; EX_D1 = 32'd21; EX_D2 = 32'd4;
        @(posedge clock);
        #1 begin EX_LO_WEN = 1'b0; EX_start = 1'b0; end
        @(negedge clock);
        checks++; if (MD_LO !== 32'd21) begin fails++; $display("FAIL strobe_start_lo: got %h expected %h", MD_LO, 32'd21); end
        repeat (33) @(negedge clock);
        checks++; if ({MD_HI, MD_LO} !== {32'd1, 32'd5}) begin fails++; $display("FAIL strobe_start_result: got %h expected %h", {MD_HI, MD_LO}, {32'd1, 32'd5}); end
    endtask

`ifdef MULDIV_FAST_MULT_EN
    task automatic test_fast;
        run_op(MD_MULT, 32'd6, 32'd7, 1);
        checks++; if ({hi_r, lo_r} !== 64'h2A) begin fails++; $display("FAIL fast_mult: got %h expected %h", {hi_r, lo_r}, 64'h2A); end
        checks++; if (bc !== 1 || dc !== 1) begin fails++; $display("FAIL fast_timing: got busy %0d done %0d expected 1 1", bc, dc); end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
`ifndef MULDIV_FAST_MULT_EN
        test_ignore_start();
`endif
        test_abort();
        test_reset_mid();
        test_strobe();
`ifdef MULDIV_FAST_MULT_EN
        test_fast();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
